// File: rtl/msrv32_machine_control_if.sv
// Instruction, status and strobe bundle between the RV32I core datapath and its trap sequencer.
// The master side drives decoded fields and event lines; the slave side is the sequencer.
interface msrv32_machine_control_if;
   logic       ahb_ready_in;
   logic [4:0] opcode_6_to_2_in;
   logic [2:0] funct3_in;
   logic [6:0] funct7_in;
   logic [4:0] rs1_addr_in;
   logic [4:0] rs2_addr_in;
   logic [4:0] rd_addr_in;
   logic       illegal_instr_in;
   logic       misaligned_instr_in;
   logic       misaligned_load_in;
   logic       misaligned_store_in;
   logic       mie_in;
   logic       meie_in;
   logic       mtie_in;
   logic       msie_in;
   logic       meip_in;
   logic       mtip_in;
   logic       msip_in;
   logic [1:0] pc_src_out;
   logic       flush_out;
   logic       trap_taken_out;
   logic       i_or_e_out;
   logic [3:0] cause_out;
   logic       set_cause_out;
   logic       set_epc_out;
   logic       mie_clear_out;
   logic       mie_set_out;
   logic       misaligned_exception_out;
   logic       instret_inc_out;

   modport master (
      output ahb_ready_in, opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in,
             rd_addr_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in,
             misaligned_store_in, mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
      input  pc_src_out, flush_out, trap_taken_out, i_or_e_out, cause_out, set_cause_out,
             set_epc_out, mie_clear_out, mie_set_out, misaligned_exception_out, instret_inc_out
   );

   modport slave (
      input  ahb_ready_in, opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in,
             rd_addr_in, illegal_instr_in, misaligned_instr_in, misaligned_load_in,
             misaligned_store_in, mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
      output pc_src_out, flush_out, trap_taken_out, i_or_e_out, cause_out, set_cause_out,
             set_epc_out, mie_clear_out, mie_set_out, misaligned_exception_out, instret_inc_out
   );
endinterface

// File: rtl/msrv32_machine_control.sv
// Trap/return sequencer: selects the PC source, flushes the pipe and strobes mepc/mcause/MIE
// on trap entry and MRET.
module msrv32_machine_control #(
   parameter int unsigned BOOT_CYCLES = 1
) (
   input logic                      clk_in,
   input logic                      rst_in,
   msrv32_machine_control_if.slave  bus_io
);
   localparam int unsigned CntW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(BOOT_CYCLES - 1);

   typedef enum logic [1:0] {StReset, StOperating, StTrapTaken, StTrapReturn} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] boot_cnt_q, boot_cnt_d;
   logic            i_or_e_q;
   logic [3:0]      cause_q;
   logic            misaligned_q;

   logic        sys_match;
   logic [11:0] sys_field;
   logic        is_ecall, is_ebreak, is_mret;
   logic        exc_valid, exc_misaligned, irq_valid;
   logic [3:0]  exc_cause, irq_cause;

   assign sys_match = (bus_io.opcode_6_to_2_in == 5'b11100) && (bus_io.funct3_in == 3'b000) &&
                      (bus_io.rs1_addr_in == 5'd0) && (bus_io.rd_addr_in == 5'd0);
   assign sys_field = {bus_io.funct7_in, bus_io.rs2_addr_in};
   assign is_ecall  = sys_match && (sys_field == 12'h000);
   assign is_ebreak = sys_match && (sys_field == 12'h001);
   assign is_mret   = sys_match && (sys_field == 12'h302);

   always_comb begin
      exc_valid      = 1'b1;
      exc_misaligned = 1'b0;
      exc_cause      = 4'd0;
      if (bus_io.misaligned_instr_in) begin
         exc_cause      = 4'd0;
         exc_misaligned = 1'b1;
      end else if (bus_io.illegal_instr_in) begin
         exc_cause = 4'd2;
      end else if (is_ebreak) begin
         exc_cause = 4'd3;
      end else if (is_ecall) begin
         exc_cause = 4'd11;
      end else if (bus_io.misaligned_store_in) begin
         exc_cause      = 4'd6;
         exc_misaligned = 1'b1;
      end else if (bus_io.misaligned_load_in) begin
         exc_cause      = 4'd4;
         exc_misaligned = 1'b1;
      end else begin
         exc_valid = 1'b0;
      end
   end

   always_comb begin
      irq_valid = bus_io.mie_in;
      irq_cause = 4'd0;
      if (bus_io.meie_in && bus_io.meip_in) begin
         irq_cause = 4'd11;
      end else if (bus_io.msie_in && bus_io.msip_in) begin
         irq_cause = 4'd3;
      end else if (bus_io.mtie_in && bus_io.mtip_in) begin
         irq_cause = 4'd7;
      end else begin
         irq_valid = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      boot_cnt_d = boot_cnt_q;
      unique case (state_q)
         StReset: begin
            if (boot_cnt_q == LastCnt) state_d = StOperating;
            else                       boot_cnt_d = boot_cnt_q + CntW'(1);
         end
         StOperating: begin
            if (bus_io.ahb_ready_in) begin
               if (exc_valid || irq_valid) state_d = StTrapTaken;
               else if (is_mret)           state_d = StTrapReturn;
            end
         end
         StTrapTaken:  state_d = StOperating;
         StTrapReturn: state_d = StOperating;
      endcase
      // Reset overrides any in-flight trap or return.
      if (rst_in) begin
         state_d    = StReset;
         boot_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      if (rst_in) begin
         i_or_e_q     <= 1'b0;
         cause_q      <= 4'd0;
         misaligned_q <= 1'b0;
      end else if (state_q == StOperating && state_d == StTrapTaken) begin
         i_or_e_q     <= ~exc_valid;
         cause_q      <= exc_valid ? exc_cause : irq_cause;
         misaligned_q <= exc_valid & exc_misaligned;
      end
   end

   always_comb begin
      bus_io.pc_src_out     = 2'b11;
      bus_io.flush_out      = 1'b0;
      bus_io.trap_taken_out = 1'b0;
      unique case (state_d)
         StReset: begin
            bus_io.pc_src_out = 2'b00;
            bus_io.flush_out  = 1'b1;
         end
         StOperating: begin
            bus_io.pc_src_out = 2'b11;
         end
         StTrapTaken: begin
            bus_io.pc_src_out     = 2'b10;
            bus_io.flush_out      = 1'b1;
            bus_io.trap_taken_out = 1'b1;
         end
         StTrapReturn: begin
            bus_io.pc_src_out = 2'b01;
            bus_io.flush_out  = 1'b1;
         end
      endcase
   end

   assign bus_io.set_cause_out            = (state_q == StTrapTaken);
   assign bus_io.set_epc_out              = (state_q == StTrapTaken);
   assign bus_io.mie_clear_out            = (state_q == StTrapTaken);
   assign bus_io.misaligned_exception_out = (state_q == StTrapTaken) && misaligned_q;
   assign bus_io.mie_set_out              = (state_q == StTrapReturn);
   assign bus_io.i_or_e_out               = i_or_e_q;
   assign bus_io.cause_out                = cause_q;
   assign bus_io.instret_inc_out          = (state_q == StOperating) &&
                                            (state_d == StOperating) && bus_io.ahb_ready_in;
endmodule
